// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-path blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_parity_checker_if.sv
// Sampler/status bundle between the RX bit sampler and the parity checker.
interface uart_parity_checker_if #(
  parameter int unsigned CNT_WIDTH = 8
);

  logic                 frame_start;
  logic                 par_en;
  logic                 par_typ;
  logic                 bit_strobe;
  logic                 sampled_bit;
  logic                 err_clr;
  logic                 busy;
  logic                 par_done;
  logic                 par_err;
  logic                 err_sticky;
  logic [CNT_WIDTH-1:0] err_count;

  modport master (
    output frame_start, par_en, par_typ, bit_strobe, sampled_bit, err_clr,
    input  busy, par_done, par_err, err_sticky, err_count
  );

  modport slave (
    input  frame_start, par_en, par_typ, bit_strobe, sampled_bit, err_clr,
    output busy, par_done, par_err, err_sticky, err_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a simultaneous inc wins over clr and loads 1.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_parity_checker.sv
// Serial parity checker for the UART RX path with sticky error flag.
// Define UART_PAR_ERR_CNT_EN to build the saturating error counter; otherwise err_count is 0.
module uart_parity_checker
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_parity_checker_if.slave  bus
);

  localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);

  state_t         state;
  logic [BCW-1:0] bit_cnt;
  logic           acc;
  logic           typ_q;
  logic           par_done_q;
  logic           par_err_q;
  logic           sticky_q;
  logic           mismatch;
  logic           err_evt;

  assign mismatch = bus.sampled_bit != (acc ^ (typ_q == PAR_ODD));
  // frame_start aborts a frame even on its parity strobe, so no error is reported then
  assign err_evt  = (state == PARITY) && bus.bit_strobe && !bus.frame_start && mismatch;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      acc        <= 1'b0;
      typ_q      <= PAR_EVEN;
      par_done_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      par_done_q <= 1'b0;
      par_err_q  <= 1'b0;
      if (bus.frame_start) begin
        typ_q   <= bus.par_typ;
        acc     <= 1'b0;
        bit_cnt <= '0;
        state   <= bus.par_en ? DATA : IDLE;
      end else begin
        case (state)
          DATA: begin
            if (bus.bit_strobe) begin
              acc     <= acc ^ bus.sampled_bit;
              bit_cnt <= bit_cnt + BCW'(1);
              if (bit_cnt == BCW'(DATA_WIDTH - 1)) state <= PARITY;
            end
          end
          PARITY: begin
            if (bus.bit_strobe) begin
              par_done_q <= 1'b1;
              par_err_q  <= mismatch;
              state      <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sticky_q <= 1'b0;
    end else if (err_evt) begin
      sticky_q <= 1'b1;
    end else if (bus.err_clr) begin
      sticky_q <= 1'b0;
    end
  end

`ifdef UART_PAR_ERR_CNT_EN
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_err_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (err_evt),
    .clr   (bus.err_clr),
    .count (bus.err_count)
  );
`else
  assign bus.err_count = CNT_WIDTH'(0);
`endif

  assign bus.busy       = (state != IDLE);
  assign bus.par_done   = par_done_q;
  assign bus.par_err    = par_err_q;
  assign bus.err_sticky = sticky_q;

endmodule
